// File: rtl/fir_mac_scheduler_if.sv
// fir_mac_scheduler_if: sample input, coefficient write and band-result handshakes of the shared-MAC FIR scheduler.
interface fir_mac_scheduler_if #(parameter int NTAPS = 8, parameter int NBANDS = 4);
  localparam int CAW = $clog2(NBANDS * NTAPS);
  localparam int BW = NBANDS > 1 ? $clog2(NBANDS) : 1;
  logic in_valid;
  logic in_ready;
  logic [9:0] in_data;
  logic cfg_we;
  logic [CAW-1:0] cfg_addr;
  logic [9:0] cfg_data;
  logic cfg_ready;
  logic out_valid;
  logic out_ready;
  logic [BW-1:0] out_band;
  logic [18:0] out_data;
  modport master (
    output in_valid, in_data, cfg_we, cfg_addr, cfg_data, out_ready,
    input in_ready, cfg_ready, out_valid, out_band, out_data
  );
  modport slave (
    input in_valid, in_data, cfg_we, cfg_addr, cfg_data, out_ready,
    output in_ready, cfg_ready, out_valid, out_band, out_data
  );
endinterface

// File: rtl/fir_mac_scheduler.sv
// fir_mac_scheduler: one shared sign-magnitude multiplier and adder sequenced over all taps and bands.
// FIR_COEF_SHADOW_EN adds a shadow coefficient bank copied to the active bank on each sample accept.
module Fx_10bit_Multiplier (
  input  logic [9:0]  a,
  input  logic [9:0]  b,
  output logic [18:0] p
);
  assign p = {a[9] ^ b[9], 18'(a[8:0]) * 18'(b[8:0])};
endmodule

module Fx_19bit_adder (
  input  logic [18:0] a,
  input  logic [18:0] b,
  output logic [18:0] s
);
  logic same, a_ge;
  assign same = a[18] == b[18];
  assign a_ge = a[17:0] >= b[17:0];
  assign s[17:0] = same ? a[17:0] + b[17:0] : a_ge ? a[17:0] - b[17:0] : b[17:0] - a[17:0];
  assign s[18] = same | a_ge ? a[18] : b[18];
endmodule

module fir_mac_scheduler #(
  parameter int NTAPS = 8,
  parameter int NBANDS = 4
) (
  input logic clk,
  input logic rst,
  fir_mac_scheduler_if.slave bus
);
  localparam int CAW = $clog2(NBANDS * NTAPS);
  localparam int TW = $clog2(NTAPS);
  localparam int BW = NBANDS > 1 ? $clog2(NBANDS) : 1;
`ifdef FIR_COEF_SHADOW_EN
  localparam logic SHADOW = 1'b1;
`else
  localparam logic SHADOW = 1'b0;
`endif
  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_OUT} state_t;
  state_t state;
  logic [TW-1:0] wp, k;
  logic [BW-1:0] band;
  logic [9:0] dl [NTAPS];
  logic [9:0] coef [NBANDS*NTAPS];
  logic [CAW-1:0] rd_addr;
  logic [9:0] c_rd, x_rd;
  logic [18:0] prod, prod_reg, acc, sum, acc_next;
  logic mac_v, mac_first, accept, wr_ok;
  assign accept = bus.in_valid & bus.in_ready;
  assign wr_ok = bus.cfg_we & bus.cfg_ready & (int'(bus.cfg_addr) < NBANDS * NTAPS);
  assign rd_addr = CAW'(int'(band) * NTAPS + int'(k));
  assign x_rd = dl[wp - k];
  Fx_10bit_Multiplier u_mul (.a(c_rd), .b(x_rd), .p(prod));
  Fx_19bit_adder u_add (.a(acc), .b(prod_reg), .s(sum));
  always_comb begin
    acc_next = mac_v ? (mac_first ? prod_reg : sum) : acc;
  end
`ifdef FIR_COEF_SHADOW_EN
  logic [9:0] shadow [NBANDS*NTAPS];
  logic dirty, copy_cyc, copy;
  assign copy = copy_cyc & dirty;
  // During the copy cycle the active bank is stale, so tap 0 reads straight from the shadow.
  always_comb begin
    c_rd = copy ? shadow[rd_addr] : coef[rd_addr];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NBANDS * NTAPS; i++) begin
        coef[i] <= '0;
        shadow[i] <= '0;
      end
      dirty <= 1'b0;
      copy_cyc <= 1'b0;
    end else begin
      copy_cyc <= accept;
      dirty <= wr_ok | (dirty & ~copy);
      if (wr_ok) shadow[bus.cfg_addr] <= bus.cfg_data;
      if (copy) for (int i = 0; i < NBANDS * NTAPS; i++) coef[i] <= shadow[i];
    end
  end
`else
  always_comb begin
    c_rd = coef[rd_addr];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NBANDS * NTAPS; i++) coef[i] <= '0;
    end else if (wr_ok) begin
      coef[bus.cfg_addr] <= bus.cfg_data;
    end
  end
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      bus.in_ready <= 1'b1;
      bus.cfg_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_band <= '0;
      bus.out_data <= '0;
      wp <= '0;
      k <= '0;
      band <= '0;
      for (int i = 0; i < NTAPS; i++) dl[i] <= '0;
      prod_reg <= '0;
      acc <= '0;
      mac_v <= 1'b0;
      mac_first <= 1'b0;
    end else begin
      prod_reg <= prod;
      mac_v <= state == S_MAC;
      mac_first <= state == S_MAC && k == '0;
      acc <= acc_next;
      case (state)
        S_IDLE: if (accept) begin
          dl[wp + TW'(1)] <= bus.in_data;
          wp <= wp + TW'(1);
          k <= '0;
          band <= '0;
          bus.in_ready <= 1'b0;
          bus.cfg_ready <= SHADOW;
          state <= S_MAC;
        end
        S_MAC: begin
          k <= k + TW'(1);
          if (k == TW'(NTAPS - 1)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          bus.out_valid <= 1'b1;
          bus.out_band <= band;
          bus.out_data <= {acc_next[18] & |acc_next[17:0], acc_next[17:0]};
          state <= S_OUT;
        end
        S_OUT: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          k <= '0;
          if (band == BW'(NBANDS - 1)) begin
            bus.in_ready <= 1'b1;
            bus.cfg_ready <= 1'b1;
            state <= S_IDLE;
          end else begin
            band <= band + BW'(1);
            state <= S_MAC;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_scheduler.sv
// tb_fir_mac_scheduler: directed vectors for the shared-MAC FIR scheduler.
module tb_fir_mac_scheduler;
  localparam int NT = 8;
  localparam int NB = 4;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fir_mac_scheduler_if #(.NTAPS(NT), .NBANDS(NB)) bus ();
  fir_mac_scheduler #(.NTAPS(NT), .NBANDS(NB)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic [9:0] c;
    logic [9:0] x;
    logic [18:0] e;
  } vec_t;
  vec_t vt [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input logic [9:0] d);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = a[4:0];
    bus.cfg_data = d;
    step;
    bus.cfg_we = 1'b0;
  endtask

  task automatic send(input logic [9:0] x);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = x;
    while (!bus.in_ready && n < 200) begin
      step;
      n++;
    end
    if (!bus.in_ready) timeout("in_ready");
    step;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out;
    int n = 0;
    while (!bus.out_valid && n < 200) begin
      step;
      n++;
    end
    if (!bus.out_valid) timeout("out_valid");
  endtask

  task automatic get_band(input int b, input logic [18:0] e);
    wait_out;
    check($sformatf("band%0d index", b), 32'(bus.out_band), b);
    check($sformatf("band%0d data", b), 32'(bus.out_data), 32'(e));
    step;
  endtask

  task automatic get_sample(input logic [18:0] e0, e1, e2, e3);
    get_band(0, e0);
    get_band(1, e1);
    get_band(2, e2);
    get_band(3, e3);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step;
    rst = 1'b0;
    step;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    logic [18:0] d;
    vt[0] = '{10'h203, 10'h005, 19'h4000F};
    vt[1] = '{10'h203, 10'h205, 19'h0000F};
    vt[2] = '{10'h203, 10'h000, 19'h00000};
    vt[3] = '{10'h001, 10'h001, 19'h00001};
    vt[4] = '{10'h1FF, 10'h1FF, 19'h3FC01};
    vt[5] = '{10'h3FF, 10'h1FF, 19'h7FC01};
    vt[6] = '{10'h3FF, 10'h3FF, 19'h3FC01};
    vt[7] = '{10'h000, 10'h205, 19'h00000};
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(bus.in_ready), 1);
    check("reset cfg_ready", 32'(bus.cfg_ready), 1);
    check("reset out_valid", 32'(bus.out_valid), 0);
    check("reset out_band", 32'(bus.out_band), 0);
    check("reset out_data", 32'(bus.out_data), 0);
    rst = 1'b0;
    step;
    for (int i = 0; i < 8; i++) begin
      cfg_write(0, vt[i].c);
      send(vt[i].x);
      get_sample(vt[i].e, 0, 0, 0);
    end
    // band 0 result must appear exactly NTAPS+1 edges after the accept edge
    send(10'h005);
    repeat (NT) step;
    check("latency early", 32'(bus.out_valid), 0);
    step;
    check("latency on time", 32'(bus.out_valid), 1);
    get_sample(0, 0, 0, 0);
    cfg_write(0, 10'h003);
    bus.out_ready = 1'b0;
    send(10'h001);
    wait_out;
    check("pre-reset in_ready", 32'(bus.in_ready), 0);
    #2 rst = 1'b1;
    #1;
    check("async rst out_valid", 32'(bus.out_valid), 0);
    check("async rst in_ready", 32'(bus.in_ready), 1);
    check("async rst cfg_ready", 32'(bus.cfg_ready), 1);
    check("async rst out_data", 32'(bus.out_data), 0);
    step;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step;
    send(10'h1FF);
    get_sample(0, 0, 0, 0);
    do_reset;
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < NT; k++) cfg_write(b * NT + k, 10'(b * 16 + k + 1));
    for (int j = 0; j < NT; j++) begin
      send(j == 0 ? 10'h001 : 10'h000);
      get_sample(19'(j + 1), 19'(16 + j + 1), 19'(32 + j + 1), 19'(48 + j + 1));
    end
    send(10'h002);
    get_band(0, 19'h2);
    bus.out_ready = 1'b0;
    wait_out;
    for (int i = 0; i < 5; i++) begin
      check("hold out_valid", 32'(bus.out_valid), 1);
      check("hold out_band", 32'(bus.out_band), 1);
      check("hold out_data", 32'(bus.out_data), 32'h22);
      check("hold in_ready", 32'(bus.in_ready), 0);
      step;
    end
    bus.out_ready = 1'b1;
    get_band(1, 19'h22);
    get_band(2, 19'h42);
    wait_out;
    check("in_ready before last band", 32'(bus.in_ready), 0);
    get_band(3, 19'h62);
    check("in_ready after last band", 32'(bus.in_ready), 1);
    check("no extra result", 32'(bus.out_valid), 0);
    do_reset;
    for (int k = 0; k < NT; k++) cfg_write(k, 10'h001);
    for (int x = 1; x <= 20; x++) begin
      s = 0;
      for (int t = (x > 8 ? x - 7 : 1); t <= x; t++) s += t;
      send(10'(x));
      get_sample(19'(s), 0, 0, 0);
    end
    send(10'h000);
    step;
`ifdef FIR_COEF_SHADOW_EN
    check("cfg_ready during MAC", 32'(bus.cfg_ready), 1);
    d = 19'd110;
`else
    check("cfg_ready during MAC", 32'(bus.cfg_ready), 0);
    d = 19'd106;
`endif
    cfg_write(0, 10'h005);
    get_sample(19'd119, 0, 0, 0);
    send(10'h001);
    get_sample(d, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
